// File: rtl/hamming_job_sequencer.sv
// Hamming(7,4) job sequencer: a register-mapped host interface feeds a
// 4-entry job FIFO, a four-state FSM launches one job at a time on the
// codec, and results land in a 4-entry result FIFO with sticky status.
module hamming_job_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic [7:0] data_in,
    input  logic       data_write,
    output logic [7:0] data_out,
    output logic       codec_start,
    output logic       codec_mode,
    output logic [6:0] codec_word,
    input  logic       codec_done,
    input  logic [6:0] codec_result,
    input  logic       codec_corr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    // Last WAIT count value before the job is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_codec_start;
    logic       r_codec_mode;
    logic [6:0] r_codec_word;
    logic [7:0] r_to_cnt;

    logic [7:0] r_in_mem [4];
    logic [1:0] r_in_wr;
    logic [1:0] r_in_rd;
    logic [2:0] r_in_cnt;

    logic [7:0] r_out_mem [4];
    logic [1:0] r_out_wr;
    logic [1:0] r_out_rd;
    logic [2:0] r_out_cnt;

    logic [7:0] r_corr_cnt;
    logic       r_ovf_sticky;
    logic       r_to_sticky;

    logic       w_host_push;
    logic       w_host_ctrl;
    logic       w_flush;
    logic       w_pop_req;
    logic       w_cnt_clr;
    logic       w_stk_clr;
    logic       w_in_empty;
    logic       w_in_full;
    logic       w_in_pop;
    logic       w_in_push;
    logic       w_overflow;
    logic       w_out_empty;
    logic       w_out_full;
    logic       w_out_pop;
    logic       w_out_push;
    logic       w_timeout;
    logic       w_busy;
    logic [7:0] w_in_head;
    logic [7:0] w_status;
    logic [7:0] w_rdata;
    logic       w_unused_ok;

    // The dedicated input pins carry nothing for this block.
    assign w_unused_ok = ^ui_in;

    // Host register strobes.
    assign w_host_push = data_write && (address == 4'h0);
    assign w_host_ctrl = data_write && (address == 4'h2);
    assign w_flush     = w_host_ctrl && data_in[1];
    assign w_pop_req   = w_host_ctrl && data_in[0];
    assign w_cnt_clr   = w_host_ctrl && data_in[2];
    assign w_stk_clr   = data_write && (address == 4'h3) && data_in[0];

    // Job FIFO control: the head leaves as ISSUE ends, so a host push in
    // that same cycle is accepted even when the FIFO reads full.
    assign w_in_empty  = (r_in_cnt == 3'd0);
    assign w_in_full   = (r_in_cnt == 3'd4);
    assign w_in_pop    = (r_state == S_ISSUE) && !w_flush;
    assign w_in_push   = w_host_push && (!w_in_full || w_in_pop);
    assign w_overflow  = w_host_push && w_in_full && !w_in_pop;
    assign w_in_head   = r_in_mem[r_in_rd];

    // Result FIFO control: the codec result is written on the edge that
    // moves WAIT to STORE, making it readable one cycle after codec_done.
    assign w_out_empty = (r_out_cnt == 3'd0);
    assign w_out_full  = (r_out_cnt == 3'd4);
    assign w_out_pop   = w_pop_req && !w_flush && !w_out_empty;
    assign w_out_push  = (r_state == S_WAIT) && codec_done && !w_flush &&
                         (!w_out_full || w_out_pop);

    assign w_timeout   = (r_state == S_WAIT) && !codec_done && !w_flush &&
                         (r_to_cnt == TO_LAST);

    assign w_busy      = (r_state != S_IDLE);
    assign w_status    = {2'b00, r_to_sticky, r_ovf_sticky, w_busy,
                          w_out_full, w_out_empty, w_in_empty};

    // Sequencer FSM; codec launch signals are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_codec_start <= 1'b0;
            r_codec_mode  <= 1'b0;
            r_codec_word  <= 7'd0;
            r_to_cnt      <= 8'd0;
        end else if (w_flush) begin
            r_state       <= S_IDLE;
            r_codec_start <= 1'b0;
            r_to_cnt      <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_codec_start <= 1'b0;
                    r_to_cnt      <= 8'd0;
                    if (!w_in_empty && !w_out_full) begin
                        r_state       <= S_ISSUE;
                        r_codec_start <= 1'b1;
                        r_codec_mode  <= w_in_head[7];
                        r_codec_word  <= w_in_head[6:0];
                    end
                end
                S_ISSUE: begin
                    r_codec_start <= 1'b0;
                    r_to_cnt      <= 8'd0;
                    r_state       <= S_WAIT;
                end
                S_WAIT: begin
                    r_codec_start <= 1'b0;
                    if (codec_done) begin
                        r_state  <= S_STORE;
                        r_to_cnt <= 8'd0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state  <= S_IDLE;
                        r_to_cnt <= 8'd0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                S_STORE: begin
                    r_codec_start <= 1'b0;
                    r_to_cnt      <= 8'd0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_codec_start <= 1'b0;
                    r_to_cnt      <= 8'd0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    // Job FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_in_mem[i] <= 8'd0;
            end
            r_in_wr  <= 2'd0;
            r_in_rd  <= 2'd0;
            r_in_cnt <= 3'd0;
        end else if (w_flush) begin
            r_in_wr  <= 2'd0;
            r_in_rd  <= 2'd0;
            r_in_cnt <= 3'd0;
        end else begin
            if (w_in_push) begin
                r_in_mem[r_in_wr] <= data_in;
                r_in_wr           <= r_in_wr + 2'd1;
            end
            if (w_in_pop) begin
                r_in_rd <= r_in_rd + 2'd1;
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + 3'd1;
                2'b01:   r_in_cnt <= r_in_cnt - 3'd1;
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    // Result FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_out_mem[i] <= 8'd0;
            end
            r_out_wr  <= 2'd0;
            r_out_rd  <= 2'd0;
            r_out_cnt <= 3'd0;
        end else if (w_flush) begin
            r_out_wr  <= 2'd0;
            r_out_rd  <= 2'd0;
            r_out_cnt <= 3'd0;
        end else begin
            if (w_out_push) begin
                r_out_mem[r_out_wr] <= {codec_corr, codec_result};
                r_out_wr            <= r_out_wr + 2'd1;
            end
            if (w_out_pop) begin
                r_out_rd <= r_out_rd + 2'd1;
            end
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + 3'd1;
                2'b01:   r_out_cnt <= r_out_cnt - 3'd1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Saturating corrected-error counter; a host clear beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt <= 8'd0;
        end else if (w_cnt_clr) begin
            r_corr_cnt <= 8'd0;
        end else if (w_out_push && codec_corr && (r_corr_cnt != 8'hFF)) begin
            r_corr_cnt <= r_corr_cnt + 8'd1;
        end
    end

    // Sticky error flags; a new event in the clearing cycle stays recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_to_sticky  <= 1'b0;
        end else begin
            r_ovf_sticky <= (r_ovf_sticky && !w_stk_clr) || w_overflow;
            r_to_sticky  <= (r_to_sticky && !w_stk_clr) || w_timeout;
        end
    end

    // Register read mux; unmapped and write-only addresses read zero.
    always_comb begin
        w_rdata = 8'h00;
        case (address)
            4'h1: begin
                if (w_out_empty) begin
                    w_rdata = 8'h00;
                end else begin
                    w_rdata = r_out_mem[r_out_rd];
                end
            end
            4'h3:    w_rdata = w_status;
            4'h4:    w_rdata = r_corr_cnt;
            default: w_rdata = 8'h00;
        endcase
    end

    assign data_out    = w_rdata;
    assign uo_out      = {5'b00000, w_in_full, w_busy, !w_out_empty};
    assign codec_start = r_codec_start;
    assign codec_mode  = r_codec_mode;
    assign codec_word  = r_codec_word;

endmodule

// File: tb/tb_hamming_job_sequencer.sv
// Directed bench for hamming_job_sequencer: the bench plays the host and
// the codec, and compares outputs against hand-derived values.
module tb_hamming_job_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic [7:0] data_in;
    logic       data_write;
    logic [7:0] data_out;
    logic       codec_start;
    logic       codec_mode;
    logic [6:0] codec_word;
    logic       codec_done;
    logic [6:0] codec_result;
    logic       codec_corr;

    int n_vec;
    int n_err;

    hamming_job_sequencer #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ui_in        (ui_in),
        .uo_out       (uo_out),
        .address      (address),
        .data_in      (data_in),
        .data_write   (data_write),
        .data_out     (data_out),
        .codec_start  (codec_start),
        .codec_mode   (codec_mode),
        .codec_word   (codec_word),
        .codec_done   (codec_done),
        .codec_result (codec_result),
        .codec_corr   (codec_corr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One-cycle host register write, registered on the next edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        step();
        data_write = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        address = a;
        #1;
        v = data_out;
    endtask

    // Full job from IDLE back to IDLE with a codec answering one cycle late.
    task automatic run_job(input logic [7:0] job, input logic [6:0] res, input logic corr);
        wr(4'h0, job);
        step();
        step();
        codec_done   = 1'b1;
        codec_result = res;
        codec_corr   = corr;
        step();
        codec_done   = 1'b0;
        step();
    endtask

    logic [7:0] v;
    logic [7:0] exp_q [3];
    int n_start;
    int first_i;
    int second_i;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ui_in = 8'h00;
        address = 4'h0;
        data_in = 8'h00;
        data_write = 1'b0;
        codec_done = 1'b0;
        codec_result = 7'h00;
        codec_corr = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_start", {7'd0, codec_start}, 8'h00);
        check("rst_mode", {7'd0, codec_mode}, 8'h00);
        check("rst_word", {1'b0, codec_word}, 8'h00);
        rst_n = 1'b1;
        step();
        check("rst_uo", uo_out, 8'h00);
        rd(4'h3, v); check("rst_status", v, 8'h03);

        // Plain encode job with minimum latency.
        wr(4'h0, 8'h05);
        check("j1_idle_uo", uo_out, 8'h00);
        step();
        check("j1_start", {7'd0, codec_start}, 8'h01);
        check("j1_mode", {7'd0, codec_mode}, 8'h00);
        check("j1_word", {1'b0, codec_word}, 8'h05);
        check("j1_busy_uo", uo_out, 8'h02);
        step();
        check("j1_start_once", {7'd0, codec_start}, 8'h00);
        codec_done = 1'b1; codec_result = 7'h2D; codec_corr = 1'b0;
        step();
        codec_done = 1'b0;
        rd(4'h1, v); check("j1_result", v, 8'h2D);
        check("j1_store_uo", uo_out, 8'h03);
        step();
        check("j1_avail_uo", uo_out, 8'h01);
        wr(4'h2, 8'h01);
        rd(4'h3, v); check("j1_popped_status", v, 8'h03);

        // Decode job reporting a correction, then counter clear.
        wr(4'h0, 8'hAC);
        step();
        check("j2_mode", {7'd0, codec_mode}, 8'h01);
        check("j2_word", {1'b0, codec_word}, 8'h2C);
        step();
        codec_done = 1'b1; codec_result = 7'h2D; codec_corr = 1'b1;
        step();
        codec_done = 1'b0; codec_corr = 1'b0;
        rd(4'h1, v); check("j2_result", v, 8'hAD);
        rd(4'h4, v); check("j2_corr_cnt", v, 8'h01);
        wr(4'h2, 8'h04);
        rd(4'h4, v); check("j2_corr_clr", v, 8'h00);
        wr(4'h2, 8'h01);
        rd(4'h3, v); check("j2_status", v, 8'h03);

        // Result FIFO full holds off issue; one pop releases the pending job.
        run_job(8'h01, 7'h11, 1'b0);
        run_job(8'h02, 7'h22, 1'b0);
        run_job(8'h03, 7'h33, 1'b0);
        run_job(8'h04, 7'h44, 1'b0);
        rd(4'h3, v); check("full_status", v, 8'h05);
        wr(4'h0, 8'h0F);
        step(); step(); step();
        check("full_no_start", {7'd0, codec_start}, 8'h00);
        check("full_uo", uo_out, 8'h01);
        rd(4'h3, v); check("full_pending_status", v, 8'h04);
        wr(4'h2, 8'h01);
        rd(4'h1, v); check("full_head_after_pop", v, 8'h22);
        step();
        check("release_start", {7'd0, codec_start}, 8'h01);
        check("release_word", {1'b0, codec_word}, 8'h0F);
        step();
        // Host pop lands on the same edge as the result push.
        codec_done = 1'b1; codec_result = 7'h55; codec_corr = 1'b0;
        address = 4'h2; data_in = 8'h01; data_write = 1'b1;
        step();
        codec_done = 1'b0; data_write = 1'b0; data_in = 8'h00;
        step();
        exp_q[0] = 8'h33; exp_q[1] = 8'h44; exp_q[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            rd(4'h1, v); check($sformatf("drain_%0d", i), v, exp_q[i]);
            wr(4'h2, 8'h01);
        end
        rd(4'h1, v); check("drain_empty_read", v, 8'h00);
        wr(4'h2, 8'h01);
        rd(4'h3, v); check("empty_pop_status", v, 8'h03);

        // Flush during WAIT with codec_done in the same cycle and the next.
        wr(4'h0, 8'h01);
        wr(4'h0, 8'h02);
        wr(4'h0, 8'h03);
        rd(4'h3, v); check("flush_pre_status", v, 8'h0A);
        codec_done = 1'b1; codec_result = 7'h7F; codec_corr = 1'b1;
        address = 4'h2; data_in = 8'h02; data_write = 1'b1;
        step();
        data_write = 1'b0; data_in = 8'h00;
        step();
        codec_done = 1'b0; codec_corr = 1'b0;
        rd(4'h3, v); check("flush_status", v, 8'h03);
        rd(4'h4, v); check("flush_corr_cnt", v, 8'h00);
        check("flush_uo", uo_out, 8'h00);
        step();
        check("flush_no_start", {7'd0, codec_start}, 8'h00);

        // Silent codec: timeouts, overflow, and a push during ISSUE on a full FIFO.
        wr(4'h0, 8'h40);
        step();
        check("to_start0", {7'd0, codec_start}, 8'h01);
        step();
        // One job is in flight, so the fifth push below finds four queued.
        wr(4'h0, 8'h41);
        wr(4'h0, 8'h42);
        wr(4'h0, 8'h43);
        wr(4'h0, 8'h44);
        wr(4'h0, 8'h45);
        rd(4'h3, v); check("ovf_status", v, 8'h1A);
        for (int i = 0; i < 9; i++) step();
        check("wait_last_uo", uo_out, 8'h06);
        step();
        check("timeout_uo", uo_out, 8'h04);
        rd(4'h3, v); check("timeout_status", v, 8'h32);
        step();
        check("to_start1", {7'd0, codec_start}, 8'h01);
        check("to_word1", {1'b0, codec_word}, 8'h41);
        wr(4'h0, 8'h46);
        check("issue_push_full_uo", uo_out, 8'h06);
        n_start = 0;
        first_i = -1;
        second_i = -1;
        for (int i = 0; i < 90; i++) begin
            step();
            if (codec_start === 1'b1) begin
                n_start++;
                if (first_i < 0) first_i = i;
                else if (second_i < 0) second_i = i;
            end
        end
        check("to_start_count", 8'(n_start), 8'd4);
        check("to_job_period", 8'(second_i - first_i), 8'd17);
        check("to_last_word", {1'b0, codec_word}, 8'h46);
        check("to_end_uo", uo_out, 8'h00);
        rd(4'h3, v); check("to_end_status", v, 8'h33);
        wr(4'h3, 8'h01);
        rd(4'h3, v); check("sticky_clr_status", v, 8'h03);

        // Asynchronous reset in the middle of a WAIT cycle.
        wr(4'h0, 8'hFF);
        step();
        step();
        check("ar_pre_uo", uo_out, 8'h02);
        check("ar_pre_mode", {7'd0, codec_mode}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_uo", uo_out, 8'h00);
        check("ar_start", {7'd0, codec_start}, 8'h00);
        check("ar_mode", {7'd0, codec_mode}, 8'h00);
        check("ar_word", {1'b0, codec_word}, 8'h00);
        rd(4'h3, v); check("ar_status", v, 8'h03);
        rst_n = 1'b1;
        step();
        step();
        check("ar_after_uo", uo_out, 8'h00);
        check("ar_after_start", {7'd0, codec_start}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
